// File: rtl/rx_sequencer.sv
// UART receive sequencer: start detect, frame FSM, bit count and
// status flags (data_ready, framing_error, overrun_error).
module rx_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       shift_strobe,
  input  logic       packet_done,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       enable_timer,
  output logic       sbc_clear,
  output logic       load_buffer,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic [3:0] bit_count
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECEIVE,
    CHECK,
    LOAD
  } state_e;

  state_e     state_q, state_d;
  logic       s_cur_q, s_prev_q;
  logic [1:0] arm_q;
  logic       start;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;
  logic       fe_q, fe_d;
  logic       ovr_q, ovr_d;

  // arm_q[1] means s_prev holds a real line sample, so a line held
  // low across reset release cannot look like a falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_cur_q  <= 1'b1;
      s_prev_q <= 1'b1;
      arm_q    <= 2'b00;
    end else begin
      s_cur_q  <= serial_in;
      s_prev_q <= s_cur_q;
      arm_q    <= {arm_q[0], 1'b1};
    end
  end

  assign start = arm_q[1] & s_prev_q & ~s_cur_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          fe_d    = 1'b0;
        end
      end
      CLEAR: begin
        state_d = RECEIVE;
        cnt_d   = 4'd0;
      end
      RECEIVE: begin
        if (shift_strobe && (cnt_q != 4'hf)) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (packet_done) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (stop_bit) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          fe_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        if (rdy_q && !data_read) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A read coinciding with LOAD is absorbed by the new byte.
    if (data_read && (state_q != LOAD)) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign enable_timer  = (state_q == RECEIVE);
  assign sbc_clear     = (state_q == CLEAR);
  assign load_buffer   = (state_q == LOAD);
  assign data_ready    = rdy_q;
  assign framing_error = fe_q;
  assign overrun_error = ovr_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Testbench for rx_sequencer: directed frame table, reset and noise
// sequences, then random frames against a frame-level model.
module tb_rx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic       shift_strobe;
  logic       packet_done;
  logic       stop_bit;
  logic       data_read;
  logic       enable_timer;
  logic       sbc_clear;
  logic       load_buffer;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic [3:0] bit_count;

  rx_sequencer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .packet_done   (packet_done),
    .stop_bit      (stop_bit),
    .data_read     (data_read),
    .enable_timer  (enable_timer),
    .sbc_clear     (sbc_clear),
    .load_buffer   (load_buffer),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // frame-level model of the status flags
  bit m_dr, m_ovr, m_fe;
  int m_bc;

  bit         pend;
  logic [6:0] pend_exp;

  typedef struct {
    int         n;
    int         pd;
    bit         stop;
    bit         rdl;
    bit         rda;
    bit         chain;
    logic       dr;
    logic       ovr;
    logic       fe;
    logic [3:0] bc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] endv();
    logic [31:0] b;
    b = m_bc;
    return {m_dr, m_ovr, m_fe, b[3:0]};
  endfunction

  task automatic model_frame(input int n, input bit stop, input bit rdl);
    m_fe = !stop;
    m_bc = (n > 15) ? 15 : n;
    if (stop) begin
      if (m_dr && !rdl) m_ovr = 1'b1;
      m_dr = 1'b1;
    end else if (rdl) begin
      m_dr  = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  // k counts negedges from the one that drives the start bit low
  task automatic frame(input int n, input int pd, input bit stop,
                       input bit rdl, input bit cin, input bit cout,
                       input logic [6:0] exp_end);
    for (int k = 0; k <= pd + 3; k++) begin
      if (k == 0 && cin) continue;
      @(negedge clk);
      if (k == 1 && pend) begin
        chk("chain_end", {data_ready, overrun_error, framing_error,
                          bit_count}, pend_exp);
        pend = 1'b0;
      end
      if (k >= 1)
        chk("pulses", {enable_timer, sbc_clear, load_buffer},
            {(k >= 3 && k <= pd), (k == 2), (stop && k == pd + 2)});
      if (k == 2) chk("fe_clr", framing_error, 0);
      if (k == 3) chk("bc_clr", bit_count, 0);
      if (k == pd + 3) begin
        chk("frame_end", {data_ready, overrun_error, framing_error,
                          bit_count}, exp_end);
        data_read    = 1'b0;
        shift_strobe = 1'b0;
        packet_done  = 1'b0;
        serial_in    = 1'b1;
        break;
      end
      data_read    = (k == pd + 2) && rdl;
      shift_strobe = (k >= 3 && k <= pd && ((k - 3) % 2 == 0) &&
                      ((k - 3) / 2 < n)) ||
                     ((k < 3 || k > pd) && $urandom_range(0, 3) == 0);
      packet_done  = (k == pd) ||
                     ((k <= 2 || k > pd) && $urandom_range(0, 3) == 0);
      stop_bit     = stop;
      if (k <= 1) serial_in = 1'b0;
      else if (k <= pd - 2) serial_in = 1'($urandom_range(0, 1));
      else if (cout && k == pd + 2) serial_in = 1'b0;
      else serial_in = 1'b1;
      if (cout && k == pd + 2) begin
        pend     = 1'b1;
        pend_exp = exp_end;
        return;
      end
    end
  endtask

  task automatic gap(input int cyc, input bit allow_read);
    bit rd;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk("idle_pulses", {enable_timer, sbc_clear, load_buffer}, 0);
      chk("idle_flags", {data_ready, overrun_error}, {m_dr, m_ovr});
      rd           = allow_read && ($urandom_range(0, 4) == 0);
      data_read    = rd;
      packet_done  = 1'($urandom_range(0, 1));
      shift_strobe = 1'($urandom_range(0, 1));
      serial_in    = 1'b1;
      if (rd) begin
        m_dr  = 1'b0;
        m_ovr = 1'b0;
      end
    end
    @(negedge clk);
    chk("gap_end", {data_ready, overrun_error}, {m_dr, m_ovr});
    data_read    = 1'b0;
    packet_done  = 1'b0;
    shift_strobe = 1'b0;
  endtask

  task automatic read_pulse();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_dr  = 1'b0;
    m_ovr = 1'b0;
    chk("read_clr", {data_ready, overrun_error}, 2'b00);
  endtask

  initial begin
    bit cin;
    int n, pd;
    bit stop, rdl, cout;

    vt[0] = '{8,  100, 1, 0, 0, 0, 1, 0, 0, 4'd8};
    vt[1] = '{8,  100, 0, 0, 0, 0, 1, 0, 1, 4'd8};
    vt[2] = '{8,  40,  1, 0, 1, 0, 1, 1, 0, 4'd8};
    vt[3] = '{3,  20,  1, 0, 0, 0, 1, 0, 0, 4'd3};
    vt[4] = '{5,  20,  1, 1, 0, 0, 1, 0, 0, 4'd5};
    vt[5] = '{20, 50,  1, 0, 1, 0, 1, 1, 0, 4'd15};
    vt[6] = '{0,  10,  1, 0, 0, 1, 1, 0, 0, 4'd0};
    vt[7] = '{8,  30,  0, 0, 1, 0, 1, 0, 1, 4'd8};

    n_rst        = 1'b1;
    serial_in    = 1'b1;
    shift_strobe = 1'b0;
    packet_done  = 1'b0;
    stop_bit     = 1'b0;
    data_read    = 1'b0;
    pend         = 1'b0;
    m_dr = 0; m_ovr = 0; m_fe = 0; m_bc = 0;
    #1 n_rst = 1'b0;
    #1 chk("reset_outs", {enable_timer, sbc_clear, load_buffer,
                          data_ready, framing_error, overrun_error,
                          bit_count}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);

    // line held low through reset release must not start a frame
    n_rst     = 1'b0;
    serial_in = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_low", {enable_timer, sbc_clear}, 0);
    end
    serial_in = 1'b1;
    repeat (3) @(negedge clk);

    cin = 1'b0;
    foreach (vt[i]) begin
      frame(vt[i].n, vt[i].pd, vt[i].stop, vt[i].rdl, cin, vt[i].chain,
            {vt[i].dr, vt[i].ovr, vt[i].fe, vt[i].bc});
      m_dr = vt[i].dr; m_ovr = vt[i].ovr; m_fe = vt[i].fe; m_bc = vt[i].bc;
      cin = vt[i].chain;
      if (!vt[i].chain && vt[i].rda) read_pulse();
    end

    // reset mid-RECEIVE with bit_count = 4
    @(negedge clk);
    serial_in = 1'b0;
    stop_bit  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("mid_bc", bit_count, 4);
        chk("mid_et", enable_timer, 1);
      end
      serial_in    = (k < 2) ? 1'b0 : 1'b1;
      shift_strobe = (k == 3 || k == 5 || k == 7 || k == 9);
    end
    #2 n_rst = 1'b0;
    #1 chk("async_reset", {enable_timer, sbc_clear, load_buffer,
                           data_ready, framing_error, overrun_error,
                           bit_count}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    packet_done = 1'b1;
    m_dr = 0; m_ovr = 0; m_fe = 0; m_bc = 0;
    gap(8, 1'b0);
    chk("post_reset_fe", framing_error, 0);

    cin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n    = $urandom_range(0, 18);
      pd   = 3 + 2 * n + $urandom_range(3, 20);
      stop = ($urandom_range(0, 3) != 0);
      rdl  = ($urandom_range(0, 2) == 0);
      cout = (i < 39) && ($urandom_range(0, 3) == 0);
      model_frame(n, stop, rdl);
      frame(n, pd, stop, rdl, cin, cout, endv());
      cin = cout;
      if (!cout) gap($urandom_range(0, 6), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
